// File: rtl/l1_mac_seq.sv
// l1_mac_seq: layer-1 address sequencer and per-neuron MAC with bias, ReLU and saturation
//   clk, reset (async, active-high) | start: run request, sampled in IDLE
//   ctr1 / pix_addr: weight-row and pixel addresses | w1_flat / pix: 1-cycle-latency memory data
//   h_flat / h_valid: hidden activations and their validity | busy: RUN or DRAIN | done: result pulse
module l1_mac_seq #(
  parameter int NIN   = 784,
  parameter int NNEUR = 32,
  parameter int PAW   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [31:0]           ctr1,
  input  logic [32*NNEUR-1:0]   w1_flat,
  output logic [PAW-1:0]        pix_addr,
  input  logic [7:0]            pix,
  output logic [32*NNEUR-1:0]   h_flat,
  output logic                  h_valid,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic v1, b1, go, last;
  logic signed [47:0] acc [NNEUR];
  logic signed [40:0] prod [NNEUR];
  logic signed [47:0] s [NNEUR];
  logic [31:0] sat [NNEUR];
  assign go = state == IDLE && start;
  // v1/b1 mark the data now on w1_flat/pix as valid and as the bias row
  assign last = v1 && b1;
  assign busy = state != IDLE;
  assign pix_addr = ctr1[PAW-1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = go ? RUN :
              (state == RUN && ctr1 == 32'(NIN)) ? DRAIN :
              (state == DRAIN && last) ? IDLE : state;
  end
  always_comb begin
    for (int i = 0; i < NNEUR; i++) begin
      prod[i] = 41'($signed(w1_flat[32*i +: 32])) * 41'($signed({1'b0, pix}));
      s[i] = acc[i] + 48'($signed(w1_flat[32*i +: 32]));
      sat[i] = s[i][47] ? 32'd0 : (s[i] > 48'sh7FFF_FFFF) ? 32'h7FFF_FFFF : s[i][31:0];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr1 <= '0;
      v1 <= 1'b0;
      b1 <= 1'b0;
      h_flat <= '0;
      h_valid <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < NNEUR; i++) acc[i] <= '0;
    end else begin
      ctr1 <= (state == RUN && ctr1 != 32'(NIN)) ? ctr1 + 32'd1 : 32'd0;
      v1 <= state == RUN;
      b1 <= ctr1 == 32'(NIN);
      done <= last;
      h_valid <= go ? 1'b0 : last ? 1'b1 : h_valid;
      for (int i = 0; i < NNEUR; i++) begin
        acc[i] <= go ? 48'sd0 : (v1 && !b1) ? acc[i] + 48'(prod[i]) : acc[i];
        if (last) h_flat[32*i +: 32] <= sat[i];
      end
    end
  end
endmodule

// File: tb/tb_l1_mac_seq.sv
// tb_l1_mac_seq: directed-vector bench for l1_mac_seq with a registered weight/pixel memory model
module tb_l1_mac_seq;
  localparam int NIN = 784, NNEUR = 32, PAW = 10;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] ctr1;
  logic [32*NNEUR-1:0] w1_flat = '0, h_flat, w_row = '0, b_row = '0;
  logic [PAW-1:0] pix_addr;
  logic [7:0] pix = '0, pix_v = '0;
  logic h_valid, busy, done;
  int checks = 0, failures = 0;
  int cyc, k;
  bit seq_ok;
  l1_mac_seq #(.NIN(NIN), .NNEUR(NNEUR), .PAW(PAW)) dut (
    .clk(clk), .reset(reset), .start(start), .ctr1(ctr1), .w1_flat(w1_flat),
    .pix_addr(pix_addr), .pix(pix), .h_flat(h_flat), .h_valid(h_valid),
    .busy(busy), .done(done));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    w1_flat <= (ctr1 == 32'(NIN)) ? b_row : w_row;
    pix <= pix_v;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] lane(input int i);
    return h_flat[32*i +: 32];
  endfunction
  task automatic set_all(input logic [7:0] p, input logic [31:0] w, input logic [31:0] b);
    pix_v = p;
    w_row = {NNEUR{w}};
    b_row = {NNEUR{b}};
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ctr1"}, ctr1, 32'd0);
    chk({tag, "_pix_addr"}, 32'(pix_addr), 32'd0);
    chk({tag, "_h_or"}, 32'(|h_flat), 32'd0);
    chk({tag, "_ctl"}, {29'd0, h_valid, busy, done}, 32'd0);
  endtask
  // cyc = number of edges after the start edge; returns when done is seen or reset fires
  task automatic run(input int pulse_at, input int rst_at, input bit hold);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = hold;
    cyc = 0;
    seq_ok = 1'b1;
    while (!done && cyc < 2000) begin
      if (cyc <= NIN && (ctr1 != 32'(cyc) || pix_addr != PAW'(cyc))) seq_ok = 1'b0;
      if (cyc == NIN + 1) chk("busy_drain", 32'(busy), 32'd1);
      if (cyc == rst_at) begin
        #2 reset = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk) reset = 1'b0;
        return;
      end
      start = (cyc == pulse_at) ? 1'b1 : hold;
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_latency", 32'(cyc), 32'(NIN + 2));
    chk("addr_seq", 32'(seq_ok), 32'd1);
    chk("h_valid_at_done", 32'(h_valid), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask
  initial begin
    #12 chk_zero("reset");
    @(negedge clk) reset = 1'b0;
    set_all(8'd1, 32'd1, 32'd0);
    run(-1, -1, 1'b0);
    chk("ones_h0", lane(0), 32'd784);
    chk("ones_h31", lane(31), 32'd784);
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("h_valid_hold", 32'(h_valid), 32'd1);
    set_all(8'd255, 32'd0, 32'd5);
    w_row[31:0] = 32'hFFFF_FFFF;
    w_row[63:32] = 32'd2;
    run(-1, -1, 1'b0);
    chk("relu_h0", lane(0), 32'd0);
    chk("pos_h1", lane(1), 32'd399845);
    chk("bias_only_h2", lane(2), 32'd5);
    set_all(8'd255, 32'd0, 32'd0);
    w_row[31:0] = 32'h7FFF_FFFF;
    w_row[63:32] = 32'h0010_0000;
    b_row[95:64] = 32'h8000_0000;
    w_row[127:96] = 32'd1;
    b_row[127:96] = 32'h7FFF_FFFF;
    b_row[159:128] = 32'h7FFF_FFFF;
    b_row[191:160] = 32'hFFFF_FFFF;
    run(-1, -1, 1'b0);
    chk("wrap_neg_h0", lane(0), 32'd0);
    chk("sat_h1", lane(1), 32'h7FFF_FFFF);
    chk("neg_bias_h2", lane(2), 32'd0);
    chk("sat_bias_h3", lane(3), 32'h7FFF_FFFF);
    chk("max_exact_h4", lane(4), 32'h7FFF_FFFF);
    chk("minus1_h5", lane(5), 32'd0);
    set_all(8'd1, 32'd1, 32'd0);
    run(100, -1, 1'b0);
    chk("start_ignored_h0", lane(0), 32'd784);
    chk("start_ignored_h7", lane(7), 32'd784);
    set_all(8'd9, 32'd7, 32'd0);
    run(-1, 400, 1'b0);
    set_all(8'd2, 32'd3, 32'd1);
    run(-1, -1, 1'b0);
    chk("after_abort_h0", lane(0), 32'd4705);
    chk("after_abort_h20", lane(20), 32'd4705);
    set_all(8'd1, 32'd2, 32'd0);
    run(-1, -1, 1'b1);
    chk("b2b_first_h0", lane(0), 32'd1568);
    set_all(8'd1, 32'd3, 32'd0);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        chk("b2b_hvalid_drop", 32'(h_valid), 32'd0);
        chk("b2b_h_held", lane(0), 32'd1568);
        chk("b2b_busy", 32'(busy), 32'd1);
      end
      if (k == 786) chk("b2b_hvalid_low_786", 32'(h_valid), 32'd0);
    end while (!done && k < 2000);
    start = 1'b0;
    chk("b2b_period", 32'(k), 32'd787);
    chk("b2b_second_h0", lane(0), 32'd2352);
    chk("b2b_second_valid", 32'(h_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1 chk("idle_after_b2b", 32'(busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
